ga_issue_queue: RTL
===================

GA_ISSUE_QUEUE -- requirements
Module: ga_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries, power of two, >= 2.
REQ-002 SHALL have parameter DATA_W, default 256: multivector operand/result width.
REQ-003 SHALL have parameter FUNCT_W, default 4: opcode width.
REQ-004 SHALL have parameter ADDR_W, default 5: GA register address width.
REQ-005 SHALL have parameter LEGAL_MASK, default 16'h03FF: bit f set = opcode f legal.
REQ-006 SHALL have parameter CNT_W, default 32: perf counter width.
REQ-007 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async reset, active low.
REQ-008 SHALL provide the request port: req_valid_i in 1; req_ready_o out 1; req_funct_i in FUNCT_W; req_rd_i in ADDR_W; req_we_i in 1 (write-back enable); req_opa_i, req_opb_i in DATA_W.
REQ-009 SHALL provide the ALU issue port: alu_valid_o out 1; alu_ready_i in 1; alu_funct_o out FUNCT_W; alu_opa_o, alu_opb_o out DATA_W.
REQ-010 SHALL provide the ALU return port: alu_rvalid_i in 1; alu_result_i in DATA_W; alu_error_i in 1.
REQ-011 SHALL provide the response port: resp_valid_o out 1; resp_ready_i in 1; resp_result_o out DATA_W; resp_error_o out 1.
REQ-012 SHALL provide the write-back port: rf_we_o out 1; rf_waddr_o out ADDR_W; rf_wdata_o out DATA_W.
REQ-013 SHALL provide the status port: flush_i in 1; busy_o out 1; count_o out $clog2(DEPTH)+1; perf_ops_o, perf_err_o, perf_stall_o out CNT_W.

Function
REQ-014 SHALL accept a request when req_valid_i && req_ready_o; req_ready_o = !full && !flush_i; no bypass when full.
REQ-015 SHALL keep requests in order; pointers wrap modulo DEPTH; count_o = occupancy (0..DEPTH).
REQ-016 SHALL run an FSM with states IDLE, ISSUE, WAIT, RESP, ERR.
REQ-017 IDLE: if FIFO non-empty, pop head into the op register; go to ISSUE if LEGAL_MASK[funct] is set, else go to ERR; FIFO empty: stay.
REQ-018 ISSUE: alu_valid_o=1 with funct/operands from the op register, held stable until alu_ready_i; on alu_ready_i go to WAIT.
REQ-019 WAIT: on alu_rvalid_i capture result and error, go to RESP; alu_rvalid_i in any other state SHALL be ignored.
REQ-020 ERR: load result=0 and error=1, go to RESP; no ALU issue for an illegal opcode.
REQ-021 RESP: resp_valid_o=1 with result/error stable until resp_ready_i; on the handshake go to IDLE.
REQ-022 rf_we_o SHALL pulse for exactly the RESP handshake cycle iff we && !error, with rf_waddr_o=rd and rf_wdata_o=result.
REQ-023 Minimum latency with an empty FIFO and always-ready ALU, 1-cycle ALU return, and resp_ready_i=1:
- accept at cycle 0; pop at cycle 1; alu_valid_o at cycle 2; rvalid at cycle 3; resp_valid_o at cycle 4.
REQ-024 Pushes SHALL proceed in every FSM state; only one ALU op is outstanding.
REQ-025 flush_i SHALL empty the FIFO next cycle and block push that cycle; an op already popped SHALL complete normally.
REQ-026 busy_o = (state != IDLE) || (count_o != 0).
REQ-027 Perf counters SHALL saturate at all-ones:
- perf_ops_o +1 per RESP handshake.
- perf_err_o +1 per RESP handshake with error.
- perf_stall_o +1 per cycle with req_valid_i && !req_ready_o.

Reset
REQ-028 On rst_ni low, the block SHALL asynchronously reach:
- FSM in IDLE; FIFO empty; count_o=0.
- req_ready_o=1 once rst_ni is high.
- alu_valid_o, resp_valid_o, rf_we_o, busy_o all 0.
- op register, result, and perf counters all 0.
REQ-029 Reset mid-operation SHALL discard queued and in-flight ops; a later alu_rvalid_i SHALL be ignored.

Verification
REQ-030 Single ADD: funct=0, we=1, rd=3, ALU returns 0xA5 with 1-cycle latency -> resp_valid_o at cycle 4, result 0xA5, rf_we_o pulse with waddr=3, perf_ops_o=1.
REQ-031 Fill: alu_ready_i=0 and 5 back-to-back pushes at DEPTH=4 -> first pops, four more fill; req_ready_o low once count_o=4; perf_stall_o counts the blocked cycles.
REQ-032 Illegal opcode: funct=15 -> no alu_valid_o; resp_error_o=1, result 0, no rf_we_o, perf_err_o=1.
REQ-033 Backpressure: resp_ready_i=0 for 5 cycles -> resp_valid_o and result held stable; rf_we_o single pulse on the handshake.
REQ-034 Flush: 3 queued ops with one in WAIT, assert flush_i -> count_o=0 next cycle; in-flight op still responds; busy_o drops after its handshake.
REQ-035 Reset in WAIT, then a stray alu_rvalid_i -> no response; all outputs at reset values.

Source files
------------

// File: rtl/ga_issue_queue.sv
// ga_issue_queue: in-order request FIFO feeding a single-outstanding GA ALU.
// Requests are queued, issued one at a time, and the ALU result is returned
// on the response port with an optional register-file write-back. Illegal
// opcodes bypass the ALU and respond with an error.
module ga_issue_queue #(
  parameter int                        DEPTH      = 4,
  parameter int                        DATA_W     = 256,
  parameter int                        FUNCT_W    = 4,
  parameter int                        ADDR_W     = 5,
  parameter logic [(1<<FUNCT_W)-1:0]   LEGAL_MASK = 16'h03FF,
  parameter int                        CNT_W      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  // request
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [FUNCT_W-1:0]         req_funct_i,
  input  logic [ADDR_W-1:0]          req_rd_i,
  input  logic                       req_we_i,
  input  logic [DATA_W-1:0]          req_opa_i,
  input  logic [DATA_W-1:0]          req_opb_i,
  // ALU issue
  output logic                       alu_valid_o,
  input  logic                       alu_ready_i,
  output logic [FUNCT_W-1:0]         alu_funct_o,
  output logic [DATA_W-1:0]          alu_opa_o,
  output logic [DATA_W-1:0]          alu_opb_o,
  // ALU return
  input  logic                       alu_rvalid_i,
  input  logic [DATA_W-1:0]          alu_result_i,
  input  logic                       alu_error_i,
  // response
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [DATA_W-1:0]          resp_result_o,
  output logic                       resp_error_o,
  // write-back
  output logic                       rf_we_o,
  output logic [ADDR_W-1:0]          rf_waddr_o,
  output logic [DATA_W-1:0]          rf_wdata_o,
  // status
  input  logic                       flush_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           perf_ops_o,
  output logic [CNT_W-1:0]           perf_err_o,
  output logic [CNT_W-1:0]           perf_stall_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [ADDR_W-1:0]  rd;
    logic               we;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;

  entry_t         r_q [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count;
  state_t         r_state, w_nxt;
  entry_t         r_op;
  logic [DATA_W-1:0] r_res;
  logic           r_err;
  logic [CNT_W-1:0] r_ops, r_errs, r_stall;

  logic   w_full, w_empty, w_ready, w_push, w_pop, w_resp_hs;
  entry_t w_head, w_new;

  assign w_full    = (r_count == DEPTH[AW:0]);
  assign w_empty   = (r_count == '0);
  assign w_ready   = !w_full && !flush_i;
  assign w_push    = req_valid_i && w_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_q[r_rd_ptr];
  assign w_resp_hs = (r_state == S_RESP) && resp_ready_i;
  assign w_new     = '{funct: req_funct_i, rd: req_rd_i, we: req_we_i,
                       opa: req_opa_i, opb: req_opb_i};

  // FIFO storage; contents are don't-care while unoccupied, so no reset
  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_wr_ptr] <= w_new;
  end

  // FIFO pointers and occupancy; flush drops everything still queued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // FSM next-state: illegal opcodes are routed to ERR and never reach the ALU
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_nxt = LEGAL_MASK[w_head.funct] ? S_ISSUE : S_ERR;
      S_ISSUE: if (alu_ready_i)  w_nxt = S_WAIT;
      S_WAIT:  if (alu_rvalid_i) w_nxt = S_RESP;
      S_ERR:   w_nxt = S_RESP;
      S_RESP:  if (resp_ready_i) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: handshake valids and the single-cycle write-back strobe
  always_comb begin
    alu_valid_o  = (r_state == S_ISSUE);
    resp_valid_o = (r_state == S_RESP);
    rf_we_o      = w_resp_hs && r_op.we && !r_err;
  end

  // op register and result capture; rvalid outside WAIT is ignored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op  <= '0;
      r_res <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_pop) r_op <= w_head;
      if (r_state == S_WAIT && alu_rvalid_i) begin
        r_res <= alu_result_i;
        r_err <= alu_error_i;
      end else if (r_state == S_ERR) begin
        r_res <= '0;
        r_err <= 1'b1;
      end
    end
  end

  // saturating performance counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ops   <= '0;
      r_errs  <= '0;
      r_stall <= '0;
    end else begin
      if (w_resp_hs && r_ops != '1)           r_ops   <= r_ops + 1'b1;
      if (w_resp_hs && r_err && r_errs != '1) r_errs  <= r_errs + 1'b1;
      if (req_valid_i && !w_ready && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
  end

  assign req_ready_o   = w_ready;
  assign alu_funct_o   = r_op.funct;
  assign alu_opa_o     = r_op.opa;
  assign alu_opb_o     = r_op.opb;
  assign resp_result_o = r_res;
  assign resp_error_o  = r_err;
  assign rf_waddr_o    = r_op.rd;
  assign rf_wdata_o    = r_res;
  assign count_o       = r_count;
  assign busy_o        = (r_state != S_IDLE) || (r_count != '0);
  assign perf_ops_o    = r_ops;
  assign perf_err_o    = r_errs;
  assign perf_stall_o  = r_stall;

endmodule
